npu_host_sequencer: RTL and testbench
=====================================

Name: npu_host_sequencer

Overview:
Synthesizable host-side controller that drives the NPU's shared 32-bit bus protocol (we/oe/data/ready), replacing bench-driven stimulus. On start it streams the 6-word configuration header, then weights and inputs from a valid/ready source. It waits out the compute phase, then reads result words into a sink. It sits between a DMA/stream front end and the npu top-level.

Parameters:
DATA_W, 32, bus and stream word width
WCNT_W, 12, width of weight-count field and counter
CALC_WAIT, 5, compute-phase wait in cycles (used when the optional feature is off; timeout cap when on)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a job when idle
cfg_num_layers  in  2  header word 0
cfg_num_in  in  5  header word 1; input count minus 1
cfg_num_h1  in  5  header word 2
cfg_num_h2  in  5  header word 3
cfg_num_out  in  5  header word 4; output count minus 1
cfg_act  in  1  header word 5
cfg_num_w  in  WCNT_W  weight+bias word count (exact, 0 allowed)
src_valid  in  1  source word available
src_data  in  DATA_W  weight/input word
src_ready  out  1  source word consumed this cycle
npu_we  out  1  NPU write enable
npu_oe  out  1  NPU output enable
npu_dout  out  DATA_W  word driven onto NPU bus
npu_dout_en  out  1  bus drive enable (tristate control at top level)
npu_din  in  DATA_W  NPU bus read value
npu_ready  in  1  NPU ready
out_valid  out  1  result word valid
out_data  out  DATA_W  result word
out_last  out  1  final result word of the job
out_ready  in  1  sink accepts result
busy  out  1  job in progress
done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (synchronous, any state): state=IDLE. npu_we, npu_oe, npu_dout_en, src_ready, out_valid, out_last, busy, done all 0. npu_dout=0. Counters cleared. Reset mid-job aborts with no further bus activity.
- States: IDLE, LEAD, CFG, WGT, INP, CALC, OUT, FIN.
- IDLE: on start, latch all cfg_* into registers and go to LEAD. start in any other state is ignored. Config inputs are don't-care after the latch.
- LEAD (1 cycle): npu_we=1, npu_dout_en=1, npu_dout=0. This is the NPU's load-sync cycle.
- CFG (6 cycles): npu_we=1 and the bus drives the latched fields, zero-extended, in order: layers, in, h1, h2, out, act. Then go to WGT, or to INP if num_w=0.
- WGT/INP: src_ready=1. A word transfers when src_valid && src_ready; that cycle npu_we=1, npu_dout_en=1, npu_dout=src_data.
- WGT/INP stall (src_valid=0): npu_we=0, npu_dout_en=0. The NPU loader advances only on we-high cycles.
- WGT runs for num_w transfers; INP runs for num_in+1 transfers. After the last INP transfer go to CALC.
- CALC: we=0, bus released, counter counts CALC_WAIT cycles, then OUT.
- OUT: npu_oe = out_ready. out_valid = npu_oe, out_data = npu_din (combinational pass-through; the NPU pops one word per oe-high cycle).
- OUT: produces num_out+1 words. out_last is set with the final word. After the final accepted word go to FIN.
- FIN: done=1 for 1 cycle, then IDLE.
- busy = (state != IDLE).
- npu_we and npu_oe are never both high. npu_dout_en=0 whenever npu_we=0.
- Minimum job length with no stalls: 1+6+num_w+(num_in+1)+CALC_WAIT+(num_out+1)+1 cycles.

Optional Feature:
NPU_SEQ_READY_WAIT_EN.
- Defined: CALC exits on the first cycle npu_ready=1, sampled after at least 1 CALC cycle. If npu_ready is not seen within 64*CALC_WAIT cycles, the sequencer still proceeds to OUT and a sticky timeout_flag output (1 bit, cleared by rst or start) is set.
- Undefined: npu_ready is unused, CALC is fixed at CALC_WAIT cycles, and no timeout_flag port exists.

Test Plan:
- Single job: cfg 0/0/0/0/1/0, num_w=4, src always valid with words W0..W3,I0. Expect 12 contiguous npu_we cycles carrying 0,0,0,0,0,1,0,W0,W1,W2,W3,I0. Then 5 idle cycles. Then 2 oe cycles with out_last on the 2nd, then a done pulse.
- Source stall: drop src_valid for 3 cycles after W1. Expect 3 cycles with we=0 and dout_en=0, no word duplicated or lost, and total job length +3.
- Sink backpressure: out_ready low for 2 cycles between outputs. Expect npu_oe low during those cycles, still exactly 2 words, and out_last on the correct word.
- num_w=0 with num_in=2: CFG goes directly to INP; expect exactly 3 input words on the bus.
- Reset mid-WGT: assert rst for 1 cycle during W2. Next cycle all outputs 0 and state IDLE; a new start runs a clean job from LEAD.
- start pulsed while busy: ignored, and latched config is unchanged. With NPU_SEQ_READY_WAIT_EN, npu_ready rising 2 cycles into CALC moves the sequencer to OUT on the following cycle.

Source files
------------

// File: rtl/npu_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : npu_host_sequencer
// Description : Host-side NPU bus master: config header, weight/input stream,
//               compute wait, result read-out. Option: NPU_SEQ_READY_WAIT_EN.
// Revision    : 1.0
// ============================================================================
module npu_host_sequencer #(
  parameter int DATA_W    = 32,
  parameter int WCNT_W    = 12,
  parameter int CALC_WAIT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_num_layers,
  input  logic [4:0]        cfg_num_in,
  input  logic [4:0]        cfg_num_h1,
  input  logic [4:0]        cfg_num_h2,
  input  logic [4:0]        cfg_num_out,
  input  logic              cfg_act,
  input  logic [WCNT_W-1:0] cfg_num_w,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              npu_we,
  output logic              npu_oe,
  output logic [DATA_W-1:0] npu_dout,
  output logic              npu_dout_en,
  input  logic [DATA_W-1:0] npu_din,
  input  logic              npu_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
`ifdef NPU_SEQ_READY_WAIT_EN
  output logic              timeout_flag,
`endif
  output logic              done
);

  localparam int TMO_CYC = 64 * CALC_WAIT;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);
  localparam int CNT_W   = (WCNT_W > TMO_W) ? WCNT_W : TMO_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_CFG  = 3'd2,
    S_WGT  = 3'd3,
    S_INP  = 3'd4,
    S_CALC = 3'd5,
    S_OUT  = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        layers_q;
  logic [4:0]        num_in_q;
  logic [4:0]        num_h1_q;
  logic [4:0]        num_h2_q;
  logic [4:0]        num_out_q;
  logic              act_q;
  logic [WCNT_W-1:0] num_w_q;
  logic              timeout_q;
  logic              xfer;
  logic [DATA_W-1:0] cfg_word;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign xfer    = src_ready && src_valid;

  always_comb begin
    cfg_word = '0;
    case (cnt_q[2:0])
      3'd0:    cfg_word[1:0] = layers_q;
      3'd1:    cfg_word[4:0] = num_in_q;
      3'd2:    cfg_word[4:0] = num_h1_q;
      3'd3:    cfg_word[4:0] = num_h2_q;
      3'd4:    cfg_word[4:0] = num_out_q;
      3'd5:    cfg_word[0]   = act_q;
      default: cfg_word      = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      layers_q  <= '0;
      num_in_q  <= '0;
      num_h1_q  <= '0;
      num_h2_q  <= '0;
      num_out_q <= '0;
      act_q     <= 1'b0;
      num_w_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          layers_q  <= cfg_num_layers;
          num_in_q  <= cfg_num_in;
          num_h1_q  <= cfg_num_h1;
          num_h2_q  <= cfg_num_h2;
          num_out_q <= cfg_num_out;
          act_q     <= cfg_act;
          num_w_q   <= cfg_num_w;
          timeout_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_LEAD;
        end
        S_LEAD: begin
          cnt_q   <= '0;
          state_q <= S_CFG;
        end
        S_CFG: if (cnt_q == CNT_W'(5)) begin
          cnt_q   <= '0;
          state_q <= (num_w_q == '0) ? S_INP : S_WGT;
        end else begin
          cnt_q <= cnt_inc;
        end
        S_WGT: if (xfer) begin
          if (cnt_inc == CNT_W'(num_w_q)) begin
            cnt_q   <= '0;
            state_q <= S_INP;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_INP: if (xfer) begin
          if (cnt_q == CNT_W'(num_in_q)) begin
            cnt_q   <= '0;
            state_q <= S_CALC;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
`ifdef NPU_SEQ_READY_WAIT_EN
        // npu_ready is ignored in the first compute cycle; the cap forces progress.
        S_CALC: if ((cnt_q != '0) && npu_ready) begin
          cnt_q   <= '0;
          state_q <= S_OUT;
        end else if (cnt_inc == CNT_W'(TMO_CYC)) begin
          cnt_q     <= '0;
          timeout_q <= 1'b1;
          state_q   <= S_OUT;
        end else begin
          cnt_q <= cnt_inc;
        end
`else
        S_CALC: if (cnt_inc == CNT_W'(CALC_WAIT)) begin
          cnt_q   <= '0;
          state_q <= S_OUT;
        end else begin
          cnt_q <= cnt_inc;
        end
`endif
        S_OUT: if (out_ready) begin
          if (cnt_q == CNT_W'(num_out_q)) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_FIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef NPU_SEQ_READY_WAIT_EN
  assign timeout_flag = timeout_q;
`else
  logic unused_ready;
  assign unused_ready = npu_ready ^ timeout_q;
`endif

  assign src_ready   = (state_q == S_WGT) || (state_q == S_INP);
  assign npu_we      = (state_q == S_LEAD) || (state_q == S_CFG) || xfer;
  assign npu_dout_en = npu_we;
  assign npu_dout    = (state_q == S_CFG) ? cfg_word :
                       xfer               ? src_data : '0;
  assign npu_oe      = (state_q == S_OUT) && out_ready;
  assign out_valid   = npu_oe;
  assign out_data    = npu_din;
  assign out_last    = npu_oe && (cnt_q == CNT_W'(num_out_q));
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_npu_host_sequencer.sv
`default_nettype none
// tb_npu_host_sequencer: directed job table plus randomized jobs, each checked
// against a transaction-level model of bus writes, result reads and job length.
module tb_npu_host_sequencer;
  localparam int DATA_W    = 32;
  localparam int WCNT_W    = 12;
  localparam int CALC_WAIT = 5;

  logic              clk = 1'b0;
  logic              rst, start, src_valid, src_ready, npu_we, npu_oe, npu_dout_en;
  logic              npu_ready, out_valid, out_last, out_ready, busy, done, cfg_act;
  logic [1:0]        cfg_num_layers;
  logic [4:0]        cfg_num_in, cfg_num_h1, cfg_num_h2, cfg_num_out;
  logic [WCNT_W-1:0] cfg_num_w;
  logic [DATA_W-1:0] src_data, npu_dout, npu_din, out_data;

  always #5 clk = ~clk;

  npu_host_sequencer #(.DATA_W(DATA_W), .WCNT_W(WCNT_W), .CALC_WAIT(CALC_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_layers(cfg_num_layers), .cfg_num_in(cfg_num_in), .cfg_num_h1(cfg_num_h1),
    .cfg_num_h2(cfg_num_h2), .cfg_num_out(cfg_num_out), .cfg_act(cfg_act),
    .cfg_num_w(cfg_num_w), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .npu_we(npu_we), .npu_oe(npu_oe), .npu_dout(npu_dout),
    .npu_dout_en(npu_dout_en), .npu_din(npu_din), .npu_ready(npu_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int layers, nin, h1, h2, nout, act, nw;
    int st_at, st_len, bp_at, bp_len, bs_at;
    int exp_we, exp_len;   // 0 means derive from the model
  } job_t;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W+7:0] outs();
    return {npu_we, npu_oe, npu_dout_en, src_ready, out_valid, out_last, busy, done, npu_dout};
  endfunction

  task automatic rand_cfg();
    cfg_num_layers = 2'($urandom);
    cfg_num_in     = 5'($urandom);
    cfg_num_h1     = 5'($urandom);
    cfg_num_h2     = 5'($urandom);
    cfg_num_out    = 5'($urandom);
    cfg_act        = 1'($urandom);
    cfg_num_w      = WCNT_W'($urandom);
  endtask

  task automatic run_job(input int id, input job_t j);
    logic [DATA_W-1:0] src_w[$], exp_wr[$], res_w[$], wr_got[$], rd_got[$];
    int n_src, exp_we, exp_len, consumed, rd_cnt, st_rem, bp_rem;
    int len, done_cnt, en_err, both_err, last_idx, last_cnt;
    bit st_act, bp_act, fin;
    n_src = j.nw + j.nin + 1;
    exp_we  = (j.exp_we  != 0) ? j.exp_we  : 7 + n_src;
    exp_len = (j.exp_len != 0) ? j.exp_len :
              1 + 6 + n_src + CALC_WAIT + (j.nout + 1) + 1 + j.st_len + j.bp_len;
    consumed = 0; rd_cnt = 0; st_rem = j.st_len; bp_rem = j.bp_len;
    len = 0; done_cnt = 0; en_err = 0; both_err = 0; last_idx = -1; last_cnt = 0; fin = 0;
    exp_wr.push_back('0);
    exp_wr.push_back(DATA_W'(j.layers)); exp_wr.push_back(DATA_W'(j.nin));
    exp_wr.push_back(DATA_W'(j.h1));     exp_wr.push_back(DATA_W'(j.h2));
    exp_wr.push_back(DATA_W'(j.nout));   exp_wr.push_back(DATA_W'(j.act));
    for (int i = 0; i < n_src; i++) begin
      src_w.push_back($urandom);
      exp_wr.push_back(src_w[i]);
    end
    for (int i = 0; i <= j.nout; i++) res_w.push_back($urandom);

    @(posedge clk); #1;
    start = 1'b1;
    cfg_num_layers = 2'(j.layers); cfg_num_in = 5'(j.nin); cfg_num_h1 = 5'(j.h1);
    cfg_num_h2 = 5'(j.h2); cfg_num_out = 5'(j.nout); cfg_act = 1'(j.act);
    cfg_num_w = WCNT_W'(j.nw);
    @(posedge clk); #1;
    start = 1'b0;
    rand_cfg();
    for (int c = 0; c < 600 && !fin; c++) begin
      st_act    = (consumed == j.st_at) && (st_rem > 0);
      src_valid = (consumed < n_src) && !st_act;
      src_data  = (consumed < n_src) ? src_w[consumed] : $urandom;
      bp_act    = (rd_cnt >= 1) && (rd_cnt == j.bp_at) && (bp_rem > 0);
      out_ready = !bp_act;
      npu_din   = (rd_cnt <= j.nout) ? res_w[rd_cnt] : $urandom;
      npu_ready = 1'($urandom);
      if (j.bs_at > 0 && c == j.bs_at) begin
        start = 1'b1;
        rand_cfg();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) len++;
      if (npu_dout_en !== npu_we) en_err++;
      if (out_valid !== npu_oe) en_err++;
      if (npu_we && npu_oe) both_err++;
      if (npu_we) wr_got.push_back(npu_dout);
      if (src_ready && src_valid) consumed++;
      if (src_ready && st_act) st_rem--;
      if (bp_act) bp_rem--;
      if (npu_oe) begin
        rd_got.push_back(out_data);
        if (out_last) begin
          last_cnt++;
          last_idx = rd_cnt;
        end
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    src_valid = 1'b0;
    check($sformatf("job%0d_done_seen", id), fin, 1);
    check($sformatf("job%0d_done_pulses", id), done_cnt, 1);
    check($sformatf("job%0d_length", id), len, exp_len);
    check($sformatf("job%0d_we_count", id), wr_got.size(), exp_we);
    for (int i = 0; i < wr_got.size() && i < exp_wr.size(); i++)
      check($sformatf("job%0d_wr%0d", id, i), wr_got[i], exp_wr[i]);
    check($sformatf("job%0d_en_mismatch_cycles", id), en_err, 0);
    check($sformatf("job%0d_we_oe_overlap", id), both_err, 0);
    check($sformatf("job%0d_rd_count", id), rd_got.size(), j.nout + 1);
    for (int i = 0; i < rd_got.size() && i <= j.nout; i++)
      check($sformatf("job%0d_rd%0d", id, i), rd_got[i], res_w[i]);
    check($sformatf("job%0d_last_count", id), last_cnt, 1);
    check($sformatf("job%0d_last_index", id), last_idx, j.nout);
    @(negedge clk);
    check($sformatf("job%0d_idle_after", id), {busy, done}, 0);
  endtask

  job_t tbl[7];
  job_t rj;
  int   werr;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 0, 0, 1, 0, 4,  0, 0, 0, 0, 0, 12, 20};
    tbl[1] = '{0, 0, 0, 0, 1, 0, 4,  2, 3, 0, 0, 0, 12, 23};
    tbl[2] = '{0, 0, 0, 0, 1, 0, 4,  0, 0, 1, 2, 0, 12, 22};
    tbl[3] = '{1, 2, 3, 4, 0, 1, 0,  0, 0, 0, 0, 0, 10, 17};
    tbl[4] = '{3, 31, 31, 31, 31, 1, 10, 0, 0, 0, 0, 0, 49, 87};
    tbl[5] = '{0, 0, 0, 0, 1, 0, 4,  0, 0, 0, 0, 9, 12, 20};
    tbl[6] = '{2, 1, 5, 6, 2, 1, 3,  3, 2, 2, 1, 0, 12, 24};

    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0; npu_din = '0;
    npu_ready = 1'b0; out_ready = 1'b1; rand_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(i, tbl[i]);

    // Reset during the W2 transfer of a 4-weight job.
    @(posedge clk); #1;
    start = 1'b1; cfg_num_layers = 2'd1; cfg_num_in = 5'd0; cfg_num_h1 = 5'd0;
    cfg_num_h2 = 5'd0; cfg_num_out = 5'd0; cfg_act = 1'b0; cfg_num_w = WCNT_W'(4);
    src_valid = 1'b1; src_data = 32'h1111_0000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      src_data = 32'h1111_0000 + 32'(c);
      @(posedge clk); #1;
    end
    src_data = 32'hCAFE_0002;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_w2_we", npu_we, 1);
    check("rst_mid_w2_data", npu_dout, 32'hCAFE_0002);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", outs(), 0);
    werr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (npu_we || busy) werr++;
    end
    check("rst_mid_quiet", werr, 0);
    src_valid = 1'b0;
    run_job(7, tbl[0]);

    for (int i = 0; i < 10; i++) begin
      rj.layers = $urandom_range(0, 3);  rj.nin  = $urandom_range(0, 31);
      rj.h1     = $urandom_range(0, 31); rj.h2   = $urandom_range(0, 31);
      rj.nout   = $urandom_range(0, 31); rj.act  = $urandom_range(0, 1);
      rj.nw     = $urandom_range(0, 24);
      rj.st_at  = $urandom_range(1, rj.nw + rj.nin);
      rj.st_len = $urandom_range(0, 4);
      rj.bp_at  = (rj.nout >= 1) ? $urandom_range(1, rj.nout) : 0;
      rj.bp_len = (rj.nout >= 1) ? $urandom_range(0, 4) : 0;
      rj.bs_at  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      rj.exp_we = 0; rj.exp_len = 0;
      if (rj.nw + rj.nin == 0) rj.st_len = 0;
      run_job(8 + i, rj);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
